// File: rtl/cpu_bus_arbiter.sv
// Shares one single-ported memory between the CPU instruction and data buses.
// Captures request pulses, arbitrates round-robin, routes responses back and aborts hung transactions.
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter logic [31:0] ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpui_request,
  input  logic [31:0] cpui_addr,
  output logic [31:0] cpui_rdata,
  output logic        cpui_ack,
  input  logic        cpud_request,
  input  logic [31:0] cpud_addr,
  input  logic        cpud_write,
  input  logic [3:0]  cpud_byte_enable,
  input  logic [31:0] cpud_wdata,
  output logic [31:0] cpud_rdata,
  output logic        cpud_ack,
  output logic        mem_request,
  output logic [31:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_error,
  output logic        protocol_error,
  output logic [1:0]  debug_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} state_e;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        prefer_d_q, prefer_d_d;
  logic        i_pend_q, i_pend_d;
  logic [31:0] i_addr_q, i_addr_d;
  logic        d_pend_q, d_pend_d;
  logic [31:0] d_addr_q, d_addr_d;
  logic        d_write_q, d_write_d;
  logic [3:0]  d_be_q, d_be_d;
  logic [31:0] d_wdata_q, d_wdata_d;
  logic [31:0] wd_cnt_q, wd_cnt_d;
  logic        mem_request_q, mem_request_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        cpui_ack_q, cpui_ack_d;
  logic [31:0] cpui_rdata_q, cpui_rdata_d;
  logic        cpud_ack_q, cpud_ack_d;
  logic [31:0] cpud_rdata_q, cpud_rdata_d;
  logic        bus_error_q, bus_error_d;
  logic        protocol_error_q, protocol_error_d;

  // Handshake: every request/ack is a one-cycle pulse with no backpressure. A request
  // is consumed on the edge where it is 1; the arbiter never stalls a requester, it drops
  // a request whose bus already owns a pending or in-flight transaction and flags it.
  logic        busy, wd_expire, done, can_issue, grant_d;
  logic        drop_i, drop_d, take_i, take_d, pend_i, pend_d;
  logic [31:0] i_addr_eff, d_addr_eff, d_wdata_eff;
  logic        d_write_eff;
  logic [3:0]  d_be_eff;

  assign busy        = (state_q != IDLE);
  assign wd_expire   = WD_EN && busy && !mem_ack && (wd_cnt_q == WD_LAST);
  assign done        = busy && (mem_ack || wd_expire);
  assign can_issue   = !busy || done;
  assign drop_i      = cpui_request && (i_pend_q || state_q == BUSY_I);
  assign drop_d      = cpud_request && (d_pend_q || state_q == BUSY_D);
  assign take_i      = cpui_request && !drop_i;
  assign take_d      = cpud_request && !drop_d;
  // A request taken this edge can issue on the same edge, giving one-cycle issue latency.
  assign pend_i      = i_pend_q || take_i;
  assign pend_d      = d_pend_q || take_d;
  assign grant_d     = pend_d && (!pend_i || prefer_d_q);
  assign i_addr_eff  = take_i ? cpui_addr : i_addr_q;
  assign d_addr_eff  = take_d ? cpud_addr : d_addr_q;
  assign d_write_eff = take_d ? cpud_write : d_write_q;
  assign d_be_eff    = take_d ? cpud_byte_enable : d_be_q;
  assign d_wdata_eff = take_d ? cpud_wdata : d_wdata_q;

  always_comb begin
    state_d          = state_q;
    prefer_d_d       = prefer_d_q;
    i_pend_d         = i_pend_q;
    i_addr_d         = i_addr_q;
    d_pend_d         = d_pend_q;
    d_addr_d         = d_addr_q;
    d_write_d        = d_write_q;
    d_be_d           = d_be_q;
    d_wdata_d        = d_wdata_q;
    wd_cnt_d         = busy ? wd_cnt_q + 32'd1 : wd_cnt_q;
    mem_request_d    = 1'b0;
    mem_addr_d       = mem_addr_q;
    mem_write_d      = mem_write_q;
    mem_be_d         = mem_be_q;
    mem_wdata_d      = mem_wdata_q;
    cpui_ack_d       = 1'b0;
    cpui_rdata_d     = cpui_rdata_q;
    cpud_ack_d       = 1'b0;
    cpud_rdata_d     = cpud_rdata_q;
    bus_error_d      = 1'b0;
    protocol_error_d = drop_i || drop_d;

    if (take_i) begin
      i_pend_d = 1'b1;
      i_addr_d = cpui_addr;
    end
    if (take_d) begin
      d_pend_d  = 1'b1;
      d_addr_d  = cpud_addr;
      d_write_d = cpud_write;
      d_be_d    = cpud_byte_enable;
      d_wdata_d = cpud_wdata;
    end

    if (done) begin
      state_d     = IDLE;
      bus_error_d = !mem_ack;
      if (state_q == BUSY_I) begin
        cpui_ack_d   = 1'b1;
        cpui_rdata_d = mem_ack ? mem_rdata : ERROR_DATA;
      end else begin
        cpud_ack_d   = 1'b1;
        cpud_rdata_d = mem_ack ? mem_rdata : ERROR_DATA;
      end
    end

    if (can_issue && (pend_i || pend_d)) begin
      mem_request_d = 1'b1;
      wd_cnt_d      = 32'd0;
      if (grant_d) begin
        state_d     = BUSY_D;
        d_pend_d    = 1'b0;
        prefer_d_d  = 1'b0;
        mem_addr_d  = d_addr_eff;
        mem_write_d = d_write_eff;
        mem_be_d    = d_be_eff;
        mem_wdata_d = d_wdata_eff;
      end else begin
        state_d     = BUSY_I;
        i_pend_d    = 1'b0;
        prefer_d_d  = 1'b1;
        mem_addr_d  = i_addr_eff;
        mem_write_d = 1'b0;
        mem_be_d    = 4'hF;
        mem_wdata_d = 32'd0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      prefer_d_q       <= 1'b1;
      i_pend_q         <= 1'b0;
      i_addr_q         <= 32'd0;
      d_pend_q         <= 1'b0;
      d_addr_q         <= 32'd0;
      d_write_q        <= 1'b0;
      d_be_q           <= 4'd0;
      d_wdata_q        <= 32'd0;
      wd_cnt_q         <= 32'd0;
      mem_request_q    <= 1'b0;
      mem_addr_q       <= 32'd0;
      mem_write_q      <= 1'b0;
      mem_be_q         <= 4'd0;
      mem_wdata_q      <= 32'd0;
      cpui_ack_q       <= 1'b0;
      cpui_rdata_q     <= 32'd0;
      cpud_ack_q       <= 1'b0;
      cpud_rdata_q     <= 32'd0;
      bus_error_q      <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      prefer_d_q       <= prefer_d_d;
      i_pend_q         <= i_pend_d;
      i_addr_q         <= i_addr_d;
      d_pend_q         <= d_pend_d;
      d_addr_q         <= d_addr_d;
      d_write_q        <= d_write_d;
      d_be_q           <= d_be_d;
      d_wdata_q        <= d_wdata_d;
      wd_cnt_q         <= wd_cnt_d;
      mem_request_q    <= mem_request_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_q      <= mem_write_d;
      mem_be_q         <= mem_be_d;
      mem_wdata_q      <= mem_wdata_d;
      cpui_ack_q       <= cpui_ack_d;
      cpui_rdata_q     <= cpui_rdata_d;
      cpud_ack_q       <= cpud_ack_d;
      cpud_rdata_q     <= cpud_rdata_d;
      bus_error_q      <= bus_error_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign cpui_rdata      = cpui_rdata_q;
  assign cpui_ack        = cpui_ack_q;
  assign cpud_rdata      = cpud_rdata_q;
  assign cpud_ack        = cpud_ack_q;
  assign mem_request     = mem_request_q;
  assign mem_addr        = mem_addr_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_be_q;
  assign mem_wdata       = mem_wdata_q;
  assign bus_error       = bus_error_q;
  assign protocol_error  = protocol_error_q;
  assign debug_state     = state_q;
endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Directed bench for cpu_bus_arbiter: stimulus pushes expected events with their cycle,
// a negedge monitor pops and compares whenever the DUT emits a pulse.
module tb_cpu_bus_arbiter;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpui_request = 1'b0;
  logic [31:0] cpui_addr = 32'd0;
  logic [31:0] cpui_rdata;
  logic        cpui_ack;
  logic        cpud_request = 1'b0;
  logic [31:0] cpud_addr = 32'd0;
  logic        cpud_write = 1'b0;
  logic [3:0]  cpud_byte_enable = 4'd0;
  logic [31:0] cpud_wdata = 32'd0;
  logic [31:0] cpud_rdata;
  logic        cpud_ack;
  logic        mem_request;
  logic [31:0] mem_addr;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;
  logic        bus_error;
  logic        protocol_error;
  logic [1:0]  debug_state;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  // mem entry: {cycle[100:69], write[68], be[67:64], addr[63:32], wdata[31:0]}
  logic [100:0] mem_exp_q[$];
  logic [63:0]  i_exp_q[$];
  logic [63:0]  d_exp_q[$];
  logic [31:0]  berr_exp_q[$];
  logic [31:0]  perr_exp_q[$];

  cpu_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERROR_DATA(32'hDEADBEEF)) dut (
    .clock(clock), .reset(reset),
    .cpui_request(cpui_request), .cpui_addr(cpui_addr), .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
    .cpud_request(cpud_request), .cpud_addr(cpud_addr), .cpud_write(cpud_write),
    .cpud_byte_enable(cpud_byte_enable), .cpud_wdata(cpud_wdata), .cpud_rdata(cpud_rdata), .cpud_ack(cpud_ack),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_error(bus_error), .protocol_error(protocol_error), .debug_state(debug_state)
  );

  // Clock and cycle counter
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clock) begin
    logic [100:0] me, ma;
    logic [63:0]  ae;
    logic [31:0]  ce;
    if (mem_request) begin
      compared++;
      if (mem_exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL mem_request: unexpected at cycle %0d addr %h", cyc, mem_addr);
      end else begin
        me = mem_exp_q.pop_front();
        ma = {32'(cyc), mem_write, mem_byte_enable, mem_addr, (me[68] ? mem_wdata : 32'h0)};
        if (ma !== me) begin
          mismatched++;
          $display("FAIL mem_request: got cyc=%0d w=%b be=%h addr=%h wd=%h expected cyc=%0d w=%b be=%h addr=%h wd=%h",
                   ma[100:69], ma[68], ma[67:64], ma[63:32], ma[31:0], me[100:69], me[68], me[67:64], me[63:32], me[31:0]);
        end
      end
    end
    if (cpui_ack) begin
      compared++;
      if (i_exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL cpui_ack: unexpected at cycle %0d rdata %h", cyc, cpui_rdata);
      end else begin
        ae = i_exp_q.pop_front();
        if ({32'(cyc), cpui_rdata} !== ae) begin
          mismatched++;
          $display("FAIL cpui_ack: got cyc=%0d rdata=%h expected cyc=%0d rdata=%h", cyc, cpui_rdata, ae[63:32], ae[31:0]);
        end
      end
    end
    if (cpud_ack) begin
      compared++;
      if (d_exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL cpud_ack: unexpected at cycle %0d rdata %h", cyc, cpud_rdata);
      end else begin
        ae = d_exp_q.pop_front();
        if ({32'(cyc), cpud_rdata} !== ae) begin
          mismatched++;
          $display("FAIL cpud_ack: got cyc=%0d rdata=%h expected cyc=%0d rdata=%h", cyc, cpud_rdata, ae[63:32], ae[31:0]);
        end
      end
    end
    if (bus_error) begin
      compared++;
      if (berr_exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL bus_error: unexpected at cycle %0d", cyc);
      end else begin
        ce = berr_exp_q.pop_front();
        if (32'(cyc) !== ce) begin
          mismatched++;
          $display("FAIL bus_error: got cycle %0d expected cycle %0d", cyc, ce);
        end
      end
    end
    if (protocol_error) begin
      compared++;
      if (perr_exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL protocol_error: unexpected at cycle %0d", cyc);
      end else begin
        ce = perr_exp_q.pop_front();
        if (32'(cyc) !== ce) begin
          mismatched++;
          $display("FAIL protocol_error: got cycle %0d expected cycle %0d", cyc, ce);
        end
      end
    end
  end

  // Driver tasks
  task automatic cycle();
    @(posedge clock);
    #1;
    cpui_request = 1'b0;
    cpud_request = 1'b0;
    mem_ack      = 1'b0;
  endtask

  task automatic drive_i(input logic [31:0] a);
    cpui_request = 1'b1;
    cpui_addr    = a;
  endtask

  task automatic drive_d(input logic w, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    cpud_request     = 1'b1;
    cpud_write       = w;
    cpud_byte_enable = be;
    cpud_addr        = a;
    cpud_wdata       = wd;
  endtask

  task automatic drive_ack(input logic [31:0] rd);
    mem_ack   = 1'b1;
    mem_rdata = rd;
  endtask

  task automatic exp_mem(input int c, input logic w, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    mem_exp_q.push_back({32'(c), w, be, a, (w ? wd : 32'h0)});
  endtask

  task automatic exp_i(input int c, input logic [31:0] d);
    i_exp_q.push_back({32'(c), d});
  endtask

  task automatic exp_d(input int c, input logic [31:0] d);
    d_exp_q.push_back({32'(c), d});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_request"}, {31'd0, mem_request}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_write"}, {31'd0, mem_write}, 32'd0);
    chk({tag, "_mem_be"}, {28'd0, mem_byte_enable}, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_cpui_rdata"}, cpui_rdata, 32'd0);
    chk({tag, "_cpud_rdata"}, cpud_rdata, 32'd0);
    chk({tag, "_pulses"}, {28'd0, cpui_ack, cpud_ack, bus_error, protocol_error}, 32'd0);
    chk({tag, "_state"}, {30'd0, debug_state}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cycle();
    check_zero("reset");
    cycle();
    reset = 1'b1;
    cycle();
  endtask

  int t;

  initial begin
    do_reset();

    // Single fetch
    t = cyc;
    drive_i(32'h100); exp_mem(t + 1, 1'b0, 4'hF, 32'h100, 32'h0); cycle();
    cycle();
    cycle();
    drive_ack(32'h12345678); exp_i(t + 4, 32'h12345678); cycle();
    cycle(); cycle();

    // Simultaneous requests after reset: data first
    do_reset();
    t = cyc;
    drive_i(32'h200); drive_d(1'b1, 4'b0011, 32'h8000, 32'hA5A5A5A5);
    exp_mem(t + 1, 1'b1, 4'b0011, 32'h8000, 32'hA5A5A5A5);
    exp_mem(t + 3, 1'b0, 4'hF, 32'h200, 32'h0);
    cycle();
    cycle();
    drive_ack(32'h0BADF00D); exp_d(t + 3, 32'h0BADF00D); cycle();
    cycle();
    drive_ack(32'h22222222); exp_i(t + 5, 32'h22222222); cycle();
    cycle();

    // Round-robin with continuous requests, 1-cycle memory latency: D,I,D,I
    t = cyc;
    drive_i(32'h3000); drive_d(1'b0, 4'hF, 32'h1000, 32'h0);
    exp_mem(t + 1, 1'b0, 4'hF, 32'h1000, 32'h0); cycle();
    cycle();
    drive_ack(32'h000000D0); exp_d(t + 3, 32'h000000D0); exp_mem(t + 3, 1'b0, 4'hF, 32'h3000, 32'h0); cycle();
    drive_d(1'b0, 4'hF, 32'h1004, 32'h0); cycle();
    drive_ack(32'h00000010); exp_i(t + 5, 32'h00000010); exp_mem(t + 5, 1'b0, 4'hF, 32'h1004, 32'h0); cycle();
    drive_i(32'h3004); cycle();
    drive_ack(32'h000000D1); exp_d(t + 7, 32'h000000D1); exp_mem(t + 7, 1'b0, 4'hF, 32'h3004, 32'h0); cycle();
    cycle();
    drive_ack(32'h00000011); exp_i(t + 9, 32'h00000011); cycle();
    cycle();

    // Data granted last, then both pending: instruction wins; request on own ack cycle accepted
    t = cyc;
    drive_d(1'b1, 4'hC, 32'h1008, 32'h55AA55AA); exp_mem(t + 1, 1'b1, 4'hC, 32'h1008, 32'h55AA55AA); cycle();
    cycle();
    drive_ack(32'h0); exp_d(t + 3, 32'h0); cycle();
    drive_i(32'h3008); drive_d(1'b0, 4'hF, 32'h100C, 32'h0);
    exp_mem(t + 4, 1'b0, 4'hF, 32'h3008, 32'h0); cycle();
    cycle();
    drive_ack(32'h00000012); exp_i(t + 6, 32'h00000012); exp_mem(t + 6, 1'b0, 4'hF, 32'h100C, 32'h0); cycle();
    cycle();
    drive_ack(32'h000000D2); exp_d(t + 8, 32'h000000D2); cycle();
    cycle(); cycle();

    // Protocol violation: second data request while in flight
    t = cyc;
    drive_d(1'b0, 4'hF, 32'h4000, 32'h0); exp_mem(t + 1, 1'b0, 4'hF, 32'h4000, 32'h0); cycle();
    cycle();
    drive_d(1'b0, 4'hF, 32'h4004, 32'h0); perr_exp_q.push_back(32'(t + 3)); cycle();
    drive_ack(32'h00000044); exp_d(t + 4, 32'h00000044); cycle();
    cycle(); cycle(); cycle();

    // Protocol violation: second data request while the slot is still pending
    t = cyc;
    drive_i(32'h4100); exp_mem(t + 1, 1'b0, 4'hF, 32'h4100, 32'h0); cycle();
    drive_d(1'b0, 4'hF, 32'h4200, 32'h0); cycle();
    drive_d(1'b0, 4'hF, 32'h4204, 32'h0); perr_exp_q.push_back(32'(t + 3)); cycle();
    drive_ack(32'h00000041); exp_i(t + 4, 32'h00000041); exp_mem(t + 4, 1'b0, 4'hF, 32'h4200, 32'h0); cycle();
    cycle();
    drive_ack(32'h00000042); exp_d(t + 6, 32'h00000042); cycle();
    cycle(); cycle();

    // Watchdog expiry 8 cycles after mem_request; later stray ack ignored
    t = cyc;
    drive_i(32'h500); exp_mem(t + 1, 1'b0, 4'hF, 32'h500, 32'h0);
    exp_i(t + 9, 32'hDEADBEEF); berr_exp_q.push_back(32'(t + 9)); cycle();
    repeat (10) cycle();
    drive_ack(32'h00000099); cycle();
    cycle(); cycle();

    // Ack on the expiry cycle wins: data returned, no bus_error
    t = cyc;
    drive_i(32'h504); exp_mem(t + 1, 1'b0, 4'hF, 32'h504, 32'h0); cycle();
    repeat (7) cycle();
    drive_ack(32'h00000077); exp_i(t + 9, 32'h00000077); cycle();
    cycle(); cycle(); cycle();

    // Reset mid-transaction, late ack ignored, next request serviced
    t = cyc;
    drive_d(1'b1, 4'hF, 32'h6000, 32'h66666666); exp_mem(t + 1, 1'b1, 4'hF, 32'h6000, 32'h66666666); cycle();
    cycle();
    chk("busy_d_state", {30'd0, debug_state}, 32'd2);
    reset = 1'b0;
    #1;
    check_zero("midreset");
    cycle();
    reset = 1'b1;
    cycle();
    drive_ack(32'h00005A5A); cycle();
    cycle();
    t = cyc;
    drive_d(1'b0, 4'hF, 32'h6100, 32'h0); exp_mem(t + 1, 1'b0, 4'hF, 32'h6100, 32'h0); cycle();
    cycle();
    drive_ack(32'h00000061); exp_d(t + 3, 32'h00000061); cycle();
    cycle(); cycle(); cycle();

    // Every expected event must have been observed
    chk("leftover_mem", mem_exp_q.size(), 32'd0);
    chk("leftover_cpui", i_exp_q.size(), 32'd0);
    chk("leftover_cpud", d_exp_q.size(), 32'd0);
    chk("leftover_bus_error", berr_exp_q.size(), 32'd0);
    chk("leftover_protocol_error", perr_exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Shares one external memory port between the CPU instruction bus (cpui_*) and data bus (cpud_*).
- Sits between the cpu top level and the memory/cache system, so the core can run on a single-ported memory.
- Latches single-cycle request pulses, arbitrates round-robin, issues one transaction at a time and routes each response back to its originating bus.
- Contains a watchdog that completes a hung transaction with an error.

Parameters:
- TIMEOUT_CYCLES, 1023: cycles after mem_request with no mem_ack before the transaction is aborted; 0 disables the watchdog.
- ERROR_DATA, 32'hDEADBEEF: read data returned on a timed-out transaction.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- cpui_request  input  1  instruction fetch request, one-cycle pulse
- cpui_addr  input  32  instruction address, valid with cpui_request
- cpui_rdata  output  32  instruction data, valid with cpui_ack
- cpui_ack  output  1  instruction fetch complete, one-cycle pulse
- cpud_request  input  1  data request, one-cycle pulse
- cpud_addr  input  32  data address
- cpud_write  input  1  1 = write, 0 = read
- cpud_byte_enable  input  4  write byte lanes
- cpud_wdata  input  32  write data
- cpud_rdata  output  32  read data, valid with cpud_ack
- cpud_ack  output  1  data transaction complete, one-cycle pulse
- mem_request  output  1  memory transaction start, one-cycle pulse
- mem_addr  output  32  memory address, held until mem_ack
- mem_write  output  1  memory write
- mem_byte_enable  output  4  memory byte lanes; 4'hF for instruction fetches
- mem_wdata  output  32  memory write data
- mem_rdata  input  32  memory read data, valid with mem_ack
- mem_ack  input  1  memory response, one-cycle pulse
- bus_error  output  1  one-cycle pulse on watchdog abort
- protocol_error  output  1  one-cycle pulse when a request is dropped

Behaviour:

Reset (reset=0, asynchronous):
- All outputs 0, including rdata and mem_addr.
- Pending slots empty; state IDLE; round-robin pointer favours data; watchdog counter 0.

Request capture:
- Each bus has one pending slot, loaded on the clock edge where its request is 1 (address, write, byte_enable, wdata).
- A request arriving while that bus already has a pending or in-flight transaction is dropped, and protocol_error pulses the next cycle.
- Requests on both buses in the same cycle are both captured.

State machine (IDLE, BUSY_I, BUSY_D):
- IDLE, one slot pending: issue it.
- IDLE, both slots pending: issue the bus not granted last. After reset the data bus wins.
- Issue = mem_request high for one cycle, mem_* driven from the slot, state moves to BUSY_x, slot freed, pointer updated.
- Earliest issue is the cycle after capture, i.e. request at cycle N gives mem_request at N+1.
- mem_addr/mem_write/mem_byte_enable/mem_wdata are held stable from mem_request until mem_ack.
- BUSY_x + mem_ack:
  - At the next edge, x_rdata <= mem_rdata and x_ack pulses.
  - State goes to IDLE; if another slot is pending it issues in that same cycle. Back-to-back issues are therefore spaced two cycles apart.
- mem_ack in IDLE is ignored. This covers stray acks, including those arriving after a mid-operation reset.
- x_rdata holds its value until the next ack on that bus. cpud_rdata is updated on writes too, with whatever mem_rdata carries.

Watchdog:
- Counter clears on issue and increments each cycle in BUSY.
- On reaching TIMEOUT_CYCLES with no mem_ack:
  - x_ack pulses with x_rdata = ERROR_DATA.
  - bus_error pulses in the same cycle.
  - State returns to IDLE.
- If mem_ack and expiry coincide, mem_ack wins and there is no bus_error.

Requester timing:
- A requester may issue a new request in the same cycle its ack is high; it is accepted.

Test Plan:
1. Single fetch: cpui_request, cpui_addr=0x100 at cycle 0 -> mem_request at cycle 1 with mem_addr=0x100, mem_byte_enable=4'hF, mem_write=0. Memory acks at cycle 3 with 0x12345678 -> cpui_ack=1, cpui_rdata=0x12345678 at cycle 4; cpud_ack stays 0.
2. Simultaneous after reset: cpui (0x200) and cpud write (0x8000, wdata 0xA5A5A5A5, byte_enable 4'b0011) at cycle 0 -> data issued first at cycle 1. Ack at cycle 2 -> cpud_ack and fetch mem_request at cycle 3, mem_addr=0x200.
3. Round-robin: both buses request continuously with 1-cycle memory latency -> grants alternate D,I,D,I; neither bus waits more than one other transaction.
4. Protocol violation: a second cpud_request before the first cpud_ack -> protocol_error pulses once; only one data transaction reaches memory.
5. Timeout with TIMEOUT_CYCLES=8: fetch issued and mem_ack never comes -> cpui_ack with cpui_rdata=0xDEADBEEF and bus_error together, 8 cycles after mem_request. A mem_ack arriving later is ignored.
6. Reset mid-transaction: reset low while BUSY_D -> all outputs 0 immediately. A late mem_ack after reset releases produces no cpud_ack; the next request is serviced normally.
